// File: rtl/nco_if.sv
// nco_if: IOb-native CSR bus between a master and the nco slave.
// Carries valid/addr/wdata/wstrb requests and rdata/ready/rvalid replies.
interface nco_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    logic                  iob_valid_i;
    logic [ADDR_W-1:0]     iob_addr_i;
    logic [DATA_W-1:0]     iob_wdata_i;
    logic [DATA_W/8-1:0]   iob_wstrb_i;
    logic [DATA_W-1:0]     iob_rdata_o;
    logic                  iob_ready_o;
    logic                  iob_rvalid_o;

    modport master (
        output iob_valid_i,
        output iob_addr_i,
        output iob_wdata_i,
        output iob_wstrb_i,
        input  iob_rdata_o,
        input  iob_ready_o,
        input  iob_rvalid_o
    );

    modport slave (
        input  iob_valid_i,
        input  iob_addr_i,
        input  iob_wdata_i,
        input  iob_wstrb_i,
        output iob_rdata_o,
        output iob_ready_o,
        output iob_rvalid_o
    );
endinterface

// File: rtl/nco.sv
// nco: fractional-period clock generator (PERIOD in 24.8) with IOb CSRs.
// Define IOB_NCO_READBACK_EN to make CSR reads return register contents.
// CSR lanes: 0x0 SOFTRESET=wdata[0]/wstrb[0], 0x1 ENABLE=wdata[8]/wstrb[1],
// 0x4 PERIOD=wdata[31:0] per wstrb byte.
module nco #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int FRAC_W = 8
) (
    input  logic clk_i,
    input  logic cke_i,
    input  logic arst_n_i,
    nco_if.slave iob,
    output logic clk_out_o
);
    localparam logic [DATA_W-1:0] STEP = DATA_W'(1) << FRAC_W;
    localparam logic [DATA_W-1:0] MIN_PER = DATA_W'(2) << FRAC_W;

    logic              softreset;
    logic              enable;
    logic [DATA_W-1:0] period;
    logic [DATA_W-1:0] per_s;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W:0]   nxt;
    logic              wrap;
    logic              run;
    logic              run_q;
    logic              active;
    logic              wr;
    logic              rd;
    logic              sel_sr;
    logic              sel_en;
    logic              sel_per;

    assign iob.iob_ready_o = 1'b1;

    assign wr = iob.iob_valid_i & (|iob.iob_wstrb_i);
    assign rd = iob.iob_valid_i & ~(|iob.iob_wstrb_i);

    assign sel_sr  = iob.iob_addr_i == ADDR_W'(0);
    assign sel_en  = iob.iob_addr_i == ADDR_W'(1);
    assign sel_per = iob.iob_addr_i == ADDR_W'(4);

    // Software-visible control registers, byte-lane writes.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            softreset <= 1'b0;
            enable    <= 1'b0;
            period    <= '0;
        end else if (cke_i && wr) begin
            if (sel_sr && iob.iob_wstrb_i[0]) softreset <= iob.iob_wdata_i[0];
            if (sel_en && iob.iob_wstrb_i[1]) enable <= iob.iob_wdata_i[8];
            if (sel_per) begin
                for (int b = 0; b < DATA_W / 8; b++) begin
                    if (iob.iob_wstrb_i[b]) begin
                        period[8*b +: 8] <= iob.iob_wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read mux; compiled out when registers are write-only.
    always_comb begin
        rd_val = '0;
`ifdef IOB_NCO_READBACK_EN
        unique case (1'b1)
            sel_sr:  rd_val[0] = softreset;
            sel_en:  rd_val[8] = enable;
            sel_per: rd_val = period;
            default: rd_val = '0;
        endcase
`endif
    end

    // Read response: one-cycle rvalid pulse, data zero outside of it.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            iob.iob_rvalid_o <= 1'b0;
            iob.iob_rdata_o  <= '0;
        end else if (cke_i) begin
            iob.iob_rvalid_o <= rd;
            iob.iob_rdata_o  <= rd ? rd_val : '0;
        end
    end

    // Phase step and wrap detection, one bit wider so it cannot overflow.
    always_comb begin
        run      = enable & ~softreset & (per_s >= MIN_PER);
        active   = run & run_q;
        nxt      = {1'b0, acc} + {1'b0, STEP};
        wrap     = nxt >= {1'b0, per_s};
        acc_next = wrap ? DATA_W'(nxt - {1'b0, per_s}) : DATA_W'(nxt);
    end

    // Accumulator core; run_q adds one idle edge after start so the
    // first phase is emitted from acc=0 two edges after the enabling write.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            run_q     <= 1'b0;
            acc       <= '0;
            per_s     <= '0;
            clk_out_o <= 1'b0;
        end else if (cke_i) begin
            run_q <= run;
            if (active) begin
                clk_out_o <= acc < (per_s >> 1);
                acc       <= acc_next;
                if (wrap) per_s <= period;
            end else begin
                acc       <= '0;
                per_s     <= period;
                clk_out_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_nco.sv
// tb_nco: randomized and directed checks of nco against a closed-form
// phase model: output at active cycle n is ((n*256) mod P) < P/2.
module tb_nco;
    logic clk = 1'b0;
    logic cke;
    logic arst_n;
    logic clk_out;
    int   checks = 0;
    int   failures = 0;

    nco_if #(.ADDR_W(3), .DATA_W(32)) bus ();

    nco #(
        .DATA_W(32),
        .ADDR_W(3),
        .FRAC_W(8)
    ) dut (
        .clk_i(clk),
        .cke_i(cke),
        .arst_n_i(arst_n),
        .iob(bus),
        .clk_out_o(clk_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rb(input logic [31:0] v);
`ifdef IOB_NCO_READBACK_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    function automatic logic exp_out(input int unsigned n,
                                     input int unsigned p);
        longint unsigned ph;
        ph = (longint'(n) * 256) % longint'(p);
        return ph < longint'(p / 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        bus.iob_valid_i = 1'b1;
        bus.iob_addr_i  = a;
        bus.iob_wdata_i = d;
        bus.iob_wstrb_i = s;
        tick();
        bus.iob_valid_i = 1'b0;
        bus.iob_wstrb_i = 4'h0;
    endtask

    task automatic csr_rd(input logic [2:0] a, input logic [31:0] v,
                          input string tag);
        bus.iob_valid_i = 1'b1;
        bus.iob_addr_i  = a;
        bus.iob_wstrb_i = 4'h0;
        tick();
        bus.iob_valid_i = 1'b0;
        check({tag, "_rvalid"}, 32'(bus.iob_rvalid_o), 32'd1);
        check({tag, "_rdata"}, bus.iob_rdata_o, rb(v));
        tick();
        check({tag, "_rvalid0"}, 32'(bus.iob_rvalid_o), 32'd0);
        check({tag, "_rdata0"}, bus.iob_rdata_o, 32'd0);
    endtask

    task automatic set_sr(input logic v);
        csr_wr(3'd0, {31'd0, v}, 4'b0001);
    endtask

    task automatic set_en(input logic v);
        csr_wr(3'd1, {23'd0, v, 8'd0}, 4'b0010);
    endtask

    task automatic set_per(input logic [31:0] p);
        csr_wr(3'd4, p, 4'hf);
    endtask

    task automatic start_chk(input string tag);
        check({tag, "_e0"}, 32'(clk_out), 32'd0);
        tick();
        check({tag, "_e1"}, 32'(clk_out), 32'd0);
    endtask

    task automatic run_const(input int unsigned p, input int n,
                             input string tag);
        set_en(1'b0);
        set_per(p);
        set_en(1'b1);
        start_chk(tag);
        for (int m = 0; m < n; m++) begin
            tick();
            check(tag, 32'(clk_out), 32'(exp_out(m, p)));
        end
    endtask

    task automatic wait_high();
        for (int i = 0; i < 100 && clk_out !== 1'b1; i++) tick();
        check("wait_hi", 32'(clk_out), 32'd1);
    endtask

    task automatic gate_low(input string tag);
        tick();
        for (int i = 0; i < 6; i++) begin
            check(tag, 32'(clk_out), 32'd0);
            tick();
        end
    endtask

    task automatic run_glitch(input int m0);
        int w;
        logic e;
        set_en(1'b0);
        set_per(32'h400);
        set_en(1'b1);
        start_chk("glitch_start");
        w = m0 + ((7 - (m0 % 4)) % 4);
        if (w == m0) w += 4;
        for (int m = 0; m < m0 + 30; m++) begin
            if (m == m0) csr_wr(3'd4, 32'h800, 4'hf);
            else tick();
            e = (m <= w) ? exp_out(m, 32'h400)
                         : exp_out(m - w - 1, 32'h800);
            check("glitch", 32'(clk_out), 32'(e));
        end
    endtask

    initial begin
        int unsigned p;
        int rises[$];
        logic prev;
        logic [2:0] ua;
        int cnt;

        cke = 1'b1;
        arst_n = 1'b0;
        bus.iob_valid_i = 1'b0;
        bus.iob_addr_i  = '0;
        bus.iob_wdata_i = '0;
        bus.iob_wstrb_i = '0;

        #1000;
        check("rst_clk", 32'(clk_out), 32'd0);
        check("rst_rvalid", 32'(bus.iob_rvalid_o), 32'd0);
        check("rst_rdata", bus.iob_rdata_o, 32'd0);
        arst_n = 1'b1;
        tick();
        check("ready", 32'(bus.iob_ready_o), 32'd1);
        csr_rd(3'd0, 32'd0, "rst_sr");
        csr_rd(3'd1, 32'd0, "rst_en");
        csr_rd(3'd4, 32'd0, "rst_per");

        set_sr(1'b1);
        csr_rd(3'd0, 32'd1, "sr_rd");
        set_sr(1'b0);
        run_const(32'h400, 24, "basic");
        run_const(32'h200, 16, "min_per");

        run_glitch(5);
        run_glitch(7);

        for (int it = 0; it < 6; it++) begin
            p = $urandom_range(32'h200, 32'h2400);
            set_en(1'b0);
            csr_wr(3'd4, $urandom, 4'hf);
            csr_wr(3'd4, p, 4'b0011);
            csr_wr(3'd4, p, 4'b1100);
            ua = 3'($urandom_range(2, 7));
            if (ua == 3'd4) ua = 3'd5;
            csr_wr(ua, $urandom, 4'hf);
            csr_rd(ua, 32'd0, "unmapped");
            csr_rd(3'd4, p, "rand_per");
            set_en(1'b1);
            start_chk("rand_start");
            prev = 1'b0;
            for (int m = 0; m < 80; m++) begin
                if ($urandom_range(0, 7) == 0) begin
                    cke = 1'b0;
                    repeat ($urandom_range(1, 3)) begin
                        tick();
                        check("cke_hold", 32'(clk_out), 32'(prev));
                    end
                    cke = 1'b1;
                end
                tick();
                prev = exp_out(m, p);
                check("rand", 32'(clk_out), 32'(prev));
            end
        end

        set_en(1'b0);
        set_per(32'h1280);
        set_en(1'b1);
        start_chk("frac_start");
        prev = 1'b0;
        for (int m = 0; m < 420; m++) begin
            tick();
            if (m < 40) check("frac", 32'(clk_out), 32'(exp_out(m, 32'h1280)));
            if (clk_out && !prev) rises.push_back(m);
            prev = clk_out;
        end
        check("frac_first", 32'(rises[0]), 32'd0);
        for (int i = 1; i < rises.size(); i++) begin
            cnt = rises[i] - rises[i-1];
            check("frac_sp", 32'(cnt == 18 || cnt == 19), 32'd1);
            if (i > 1) begin
                check("frac_alt", 32'(cnt != rises[i-1] - rises[i-2]),
                      32'd1);
            end
        end
        cnt = 0;
        foreach (rises[i]) if (rises[i] < rises[0] + 370) cnt++;
        check("frac_cnt", 32'(cnt), 32'd20);

        wait_high();
        set_en(1'b0);
        gate_low("en_gate");
        csr_rd(3'd4, 32'h1280, "gate_per");
        set_en(1'b1);
        start_chk("reen");
        for (int m = 0; m < 40; m++) begin
            tick();
            check("reen", 32'(clk_out), 32'(exp_out(m, 32'h1280)));
        end
        wait_high();
        set_sr(1'b1);
        gate_low("sr_gate");
        csr_rd(3'd4, 32'h1280, "sr_per");
        csr_rd(3'd1, 32'h100, "sr_en");
        set_sr(1'b0);
        start_chk("sr_rel");
        for (int m = 0; m < 40; m++) begin
            tick();
            check("sr_rel", 32'(clk_out), 32'(exp_out(m, 32'h1280)));
        end

        bus.iob_valid_i = 1'b1;
        bus.iob_wstrb_i = 4'h0;
        bus.iob_addr_i  = 3'd4;
        tick();
        check("b2b_v0", 32'(bus.iob_rvalid_o), 32'd1);
        check("b2b_d0", bus.iob_rdata_o, rb(32'h1280));
        bus.iob_addr_i = 3'd1;
        tick();
        bus.iob_valid_i = 1'b0;
        check("b2b_v1", 32'(bus.iob_rvalid_o), 32'd1);
        check("b2b_d1", bus.iob_rdata_o, rb(32'h100));
        tick();
        check("b2b_v2", 32'(bus.iob_rvalid_o), 32'd0);

        set_en(1'b0);
        set_per(32'h1ff);
        set_en(1'b1);
        for (int m = 0; m < 60; m++) begin
            tick();
            check("illegal", 32'(clk_out), 32'd0);
        end

        run_const(32'h400, 8, "pre_arst");
        wait_high();
        #2;
        arst_n = 1'b0;
        #1;
        check("arst_clk", 32'(clk_out), 32'd0);
        check("arst_rvalid", 32'(bus.iob_rvalid_o), 32'd0);
        #2;
        arst_n = 1'b1;
        tick();
        csr_rd(3'd4, 32'd0, "arst_per");
        csr_rd(3'd1, 32'd0, "arst_en");
        check("arst_idle", 32'(clk_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
